// File: rtl/mac_pipeline_controller.sv
// Control end of the MULTIPLY | ADDITION | SUM | ACCUMULATE dot-product datapath.
// Optional stall-cycle counter enabled by defining MAC_PIPE_PERF_CNT_EN.
module mac_pipeline_controller #(
  parameter int CNT_W  = 16,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              stage_1_en,
  output logic              stage_2_en,
  output logic              stage_3_en,
  output logic              acc_en,
  output logic              acc_load,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  result_beats,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cycles
);

  // Handshakes: a transfer occurs on a cycle where valid & ready are both high;
  // in_ready never looks at in_valid, and result_valid holds until result_ready.

  logic             v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic             l1_q, l2_q, l3_q, l1_d, l2_d, l3_d;
  logic             result_valid_q, result_valid_d;
  logic             acc_first_q, acc_first_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] result_beats_q, result_beats_d;
  logic [CNT_W-1:0] cnt_new;
  logic             stall, run, accept;

  assign stall      = result_valid_q & ~result_ready;
  // Flush freezes every enable for its cycle so nothing in flight lands.
  assign run        = ~stall & ~flush;
  assign in_ready   = run & n_rst;
  assign accept     = in_valid & in_ready;
  assign stage_1_en = accept;
  assign stage_2_en = run & v1_q;
  assign stage_3_en = run & v2_q;
  assign acc_en     = run & v3_q;
  assign acc_load   = acc_en & acc_first_q;

  assign result_valid = result_valid_q;
  assign result_beats = result_beats_q;
  assign busy         = v1_q | v2_q | v3_q | result_valid_q;

  always_comb begin
    v1_d           = v1_q;
    v2_d           = v2_q;
    v3_d           = v3_q;
    l1_d           = l1_q;
    l2_d           = l2_q;
    l3_d           = l3_q;
    result_valid_d = result_valid_q;
    acc_first_d    = acc_first_q;
    beat_cnt_d     = beat_cnt_q;
    result_beats_d = result_beats_q;
    cnt_new        = acc_first_q ? CNT_W'(1)
                   : (&beat_cnt_q ? beat_cnt_q : beat_cnt_q + CNT_W'(1));
    if (flush) begin
      v1_d           = 1'b0;
      v2_d           = 1'b0;
      v3_d           = 1'b0;
      l1_d           = 1'b0;
      l2_d           = 1'b0;
      l3_d           = 1'b0;
      result_valid_d = 1'b0;
      acc_first_d    = 1'b1;
      beat_cnt_d     = '0;
    end else begin
      if (!stall) begin
        v1_d = accept;
        l1_d = in_last & accept;
        v2_d = v1_q;
        l2_d = l1_q;
        v3_d = v2_q;
        l3_d = l2_q;
      end
      if (result_valid_q && result_ready) result_valid_d = 1'b0;
      // A new result completing in the same cycle wins over the clear.
      if (acc_en) begin
        beat_cnt_d = cnt_new;
        if (l3_q) begin
          result_valid_d = 1'b1;
          result_beats_d = cnt_new;
          acc_first_d    = 1'b1;
        end else begin
          acc_first_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      v3_q           <= 1'b0;
      l1_q           <= 1'b0;
      l2_q           <= 1'b0;
      l3_q           <= 1'b0;
      result_valid_q <= 1'b0;
      acc_first_q    <= 1'b1;
      beat_cnt_q     <= '0;
      result_beats_q <= '0;
    end else begin
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      v3_q           <= v3_d;
      l1_q           <= l1_d;
      l2_q           <= l2_d;
      l3_q           <= l3_d;
      result_valid_q <= result_valid_d;
      acc_first_q    <= acc_first_d;
      beat_cnt_q     <= beat_cnt_d;
      result_beats_q <= result_beats_d;
    end
  end

`ifdef MAC_PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) stall_cnt_d = '0;
    else if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_pipeline_controller.sv
// Randomized + directed bench for mac_pipeline_controller: a beat-count reference
// model feeds an expected-result queue drained by an independent output monitor.
module tb_mac_pipeline_controller;
  localparam int CNT_W  = 16;
  localparam int PERF_W = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              flush, in_valid, in_last, result_ready;
  logic              in_ready, stage_1_en, stage_2_en, stage_3_en;
  logic              acc_en, acc_load, result_valid, busy;
  logic [CNT_W-1:0]  result_beats;
  logic [PERF_W-1:0] stall_cycles;

  mac_pipeline_controller #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .stage_1_en(stage_1_en), .stage_2_en(stage_2_en),
    .stage_3_en(stage_3_en), .acc_en(acc_en), .acc_load(acc_load),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_beats(result_beats), .busy(busy), .stall_cycles(stall_cycles)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_q[$];
  int run_cnt = 0;

  logic s_ready, s_s1, s_s2, s_s3, s_acc, s_load, s_rv, s_busy;
  logic [CNT_W-1:0]  s_beats;
  logic [PERF_W-1:0] s_stall;

`ifdef MAC_PIPE_PERF_CNT_EN
  localparam int EXP_HOLD_STALLS = 5;
`else
  localparam int EXP_HOLD_STALLS = 0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: count accepted beats per dot product; a last beat yields a
  // result whose beat count saturates at the counter's all-ones value.
  task automatic model_accept(input logic last);
    run_cnt++;
    if (last) begin
      exp_q.push_back(CNT_W'((run_cnt > CNT_MAX) ? CNT_MAX : run_cnt));
      run_cnt = 0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    run_cnt = 0;
  endtask

  // driver: one clock cycle of stimulus, then mid-cycle sampling
  task automatic step(input logic v, input logic l, input logic rr, input logic fl);
    logic exp_ready;
    @(posedge clk); #1;
    in_valid = v; in_last = l; result_ready = rr; flush = fl;
    #2;
    s_ready = in_ready; s_s1 = stage_1_en; s_s2 = stage_2_en; s_s3 = stage_3_en;
    s_acc = acc_en; s_load = acc_load; s_rv = result_valid; s_busy = busy;
    s_beats = result_beats; s_stall = stall_cycles;
    exp_ready = n_rst && !fl && !(result_valid && !rr);
    chk("in_ready_rule", s_ready, exp_ready);
    if (!exp_ready)
      chk("enables_frozen", {s_s1, s_s2, s_s3, s_acc}, 0);
    if (fl) model_clear();
    else if (v && s_ready) model_accept(l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {in_ready, stage_1_en, stage_2_en, stage_3_en, acc_en, acc_load,
               result_valid, busy}, 0);
    chk({name, "_beats"}, result_beats, 0);
    chk({name, "_stall"}, stall_cycles, 0);
  endtask

  // scoreboard monitor: pops an expected count on every output handshake
  always @(negedge clk) begin
    if (n_rst && result_valid && result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got beats=%0d expected none", result_beats);
      end else begin
        logic [CNT_W-1:0] e;
        e = exp_q.pop_front();
        if (result_beats !== e) begin
          failures++;
          $display("FAIL result_beats: got %0d expected %0d", result_beats, e);
        end
      end
    end
  end

  initial begin
    int accepted;
    int k;
    n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; result_ready = 1'b1;
    #2;
    check_all_zero("reset_state");
    @(posedge clk); #1 n_rst = 1'b1;

    // 3-beat dot product from cycle 0
    for (int c = 0; c < 8; c++) begin
      step(c <= 2, c == 2, 1'b1, 1'b0);
      chk($sformatf("t1_s1_c%0d", c), s_s1, c <= 2);
      chk($sformatf("t1_acc_c%0d", c), s_acc, c >= 3 && c <= 5);
      chk($sformatf("t1_load_c%0d", c), s_load, c == 3);
      chk($sformatf("t1_rv_c%0d", c), s_rv, c == 6);
      if (c == 6) chk("t1_beats", s_beats, 3);
    end

    // four back-to-back single-beat results
    for (int c = 0; c < 10; c++) begin
      step(c <= 3, c <= 3, 1'b1, 1'b0);
      chk($sformatf("t2_load_c%0d", c), s_load, c >= 3 && c <= 6);
      chk($sformatf("t2_rv_c%0d", c), s_rv, c >= 4 && c <= 7);
    end

    // 2-beat result held under backpressure while 3 more beats wait
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, k == 2, 1'b0, 1'b0);
      if (c == 0) chk("t3_rv_up", s_rv, 1);
      chk("t3_hold_ready", s_ready, 0);
      chk("t3_hold_en", {s_s1, s_s2, s_s3, s_acc, s_load}, 0);
      if (s_ready) k++;
    end
    accepted = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      step(1'b1, k == 2, 1'b1, 1'b0);
      if (c == 0) begin
        chk("t3_stall_cycles", s_stall, EXP_HOLD_STALLS);
        chk("t3_resume_ready", s_ready, 1);
      end
      if (s_ready) k++;
      accepted++;
    end
    chk("t3_beats_taken", k, 3);
    idle(8);

    // flush with v1 = v2 = 1 mid dot product
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_flush_ready", s_ready, 0);
    chk("t4_flush_en", {s_s1, s_s2, s_s3, s_acc}, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_busy_after", s_busy, 0);
    chk("t4_acc_after", s_acc, 0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_no_acc", s_acc, 0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_single_load", {s_acc, s_load}, 3);
    idle(4);

    // async reset mid stream
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 n_rst = 1'b0;
    #1 check_all_zero("t5_async_reset");
    model_clear();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_first_load", {s_acc, s_load}, 3);
    idle(6);

    // randomized traffic with backpressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      logic fl, rr;
      fl = ($urandom_range(0, 49) == 0);
      rr = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 1), $urandom_range(0, 3) == 0, rr, fl);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("rand_drained", exp_q.size(), 0);

    // beat counter saturation
    for (int c = 0; c < 70000; c++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    chk("final_drained", exp_q.size(), 0);
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_pipeline_controller.md
Name: mac_pipeline_controller

Overview:
- Control end of the MULTIPLY | ADDITION | SUM | ACCUMULATE datapath.
- Accepts 8-wide operand beats over a valid/ready handshake.
- Drives the stage enables of the inter-stage pipeline registers and the accumulator controls.
- Tracks per-stage valid/last flags and presents one dot-product result per `in_last` beat on a valid/ready output handshake, stalling the whole pipeline under output backpressure.

Parameters:
- CNT_W, 16: width of the beat counter and the `result_beats` output.
- PERF_W, 32: width of the stall-cycle performance counter (used only with the optional feature).

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous abort: clears all pipeline valid flags and the dot-product state
- in_valid  input  1  operand beat (8 products' inputs) presented
- in_last  input  1  beat is the final beat of the current dot product; qualified by in_valid
- in_ready  output  1  controller accepts a beat this cycle
- stage_1_en  output  1  load MULTIPLY->ADDITION registers
- stage_2_en  output  1  load ADDITION->SUM registers
- stage_3_en  output  1  load SUM->ACCUMULATE registers
- acc_en  output  1  accumulator update this cycle
- acc_load  output  1  with acc_en: load sum instead of add (first beat of a dot product)
- result_valid  output  1  accumulator holds a completed dot product
- result_ready  input  1  consumer takes the result
- result_beats  output  CNT_W  number of beats in the presented result
- busy  output  1  any pipeline stage valid or result_valid
- stall_cycles  output  PERF_W  stall cycle count (optional feature)

Behaviour:
- Reset (n_rst low, async): v1/v2/v3 and l1/l2/l3 = 0, result_valid = 0, acc_first = 1, beat_cnt = 0, result_beats = 0, stall_cycles = 0.
- Consequently all enables and in_ready are 0 while n_rst is low. They follow the equations below once reset releases.
- stall = result_valid & ~result_ready.
- in_ready = ~stall & n_rst. This is combinational; in_ready must not depend on in_valid.
- Accept = in_valid & in_ready.
- Stage enables are combinational and data-gated:
  - stage_1_en = accept
  - stage_2_en = ~stall & v1
  - stage_3_en = ~stall & v2
  - acc_en = ~stall & v3
- acc_load = acc_en & acc_first.
- Flag pipeline, when ~stall at the clock edge:
  - v1 <= accept, l1 <= in_last & accept
  - v2 <= v1, l2 <= l1
  - v3 <= v2, l3 <= l2
- When stall is high, all flags hold and all enables are 0.
- Latency: a beat accepted in cycle t produces stage_2_en in t+1, stage_3_en in t+2, and acc_en in t+3. If that beat is last, result_valid rises in t+4. Full throughput is one beat per cycle.
- Accumulator tracking on acc_en:
  - beat_cnt <= (acc_first ? 1 : beat_cnt+1), saturating at all-ones.
  - If l3: result_valid <= 1, result_beats <= that new count, acc_first <= 1.
  - Otherwise acc_first <= 0.
- result_valid clears on result_ready, unless the same cycle sets it again via acc_en & l3. The set wins: back-to-back single-beat results stream with no bubble.
- result_beats holds stable while result_valid is high.
- Stall with v3 set: the acc_en for that beat is withheld until the stall releases, so the accumulator is never overwritten before the consumer takes the result.
- flush (sync, highest priority after reset): clears v1-3, l1-3 and result_valid; sets acc_first = 1 and beat_cnt = 0. In the flush cycle, in_ready = 0 and all enables = 0.
- busy = v1 | v2 | v3 | result_valid.
- in_last on a single beat (no prior beats) is a legal 1-beat dot product with result_beats = 1.

Optional Feature:
- Macro MAC_PIPE_PERF_CNT_EN.
- Defined: stall_cycles increments every cycle stall is high, saturates at all-ones, and clears on reset and on flush.
- Undefined: the counter logic is not compiled and stall_cycles is tied to 0.

Test Plan:
- 3 beats (last on beat 3) with result_ready = 1, fed back to back from cycle 0:
  - stage_1_en high in cycles 0-2.
  - acc_en high in cycles 3-5, with acc_load only in cycle 3.
  - result_valid high in cycle 6 only, result_beats = 3.
- Four consecutive single-beat last beats with result_ready = 1: result_valid stays high for 4 consecutive cycles, result_beats = 1 each, acc_load every cycle.
- 2-beat result held with result_ready = 0 for 5 cycles while 3 more beats are pushed:
  - in_ready = 0 throughout the hold.
  - All enables = 0 throughout the hold.
  - After result_ready pulses, the pipeline resumes with no lost beats.
  - With MAC_PIPE_PERF_CNT_EN defined, stall_cycles = 5.
- flush asserted with v1 = v2 = 1 mid-dot-product:
  - Next cycle busy = 0 and no acc_en occurs.
  - A following 1-beat dot product yields acc_load = 1 and result_beats = 1.
- Async reset mid-stream (n_rst low for 2 cycles while beats are in flight): all outputs 0 immediately, acc_first = 1 after release, next result counts only post-reset beats.
- 70000 non-last beats then a last beat with CNT_W = 16: result_beats saturates at 65535.
